// File: rtl/mpmc10_req_arb256_pkg.sv
// Shared mpmc10 package slice used by the 256-bit request arbiter.
// Holds the 256-bit read/write request beat type, the arbiter state
// encoding and the default forced-release limit for locked bursts.
package mpmc10_pkg;

    typedef struct packed {
        logic [3:0]   tid;   // transaction id
        logic         we;    // 1 = write, 0 = read
        logic [31:0]  adr;   // byte address
        logic [31:0]  sel;   // byte lane enables
        logic [255:0] dat;   // write data
    } faxi_readwrite_request256_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MPMC10_MAX_LOCK_DEF = 64;

endpackage

// File: rtl/mpmc10_req_arb256_if.sv
// Request bundle between the per-port request FIFOs, the arbiter and the
// downstream 256-bit request register stage.
//   req_i/req_valid_i/lock_i/req_ready_o : per-port request side
//   req_o/req_valid_o/req_ready_i/req_port_o : arbitrated output beat
//   locked_o : arbiter currently holds a locked burst
// Modport slave is the arbiter; modport master is the surrounding logic.
interface mpmc10_req_arb256_if #(
    parameter int NPORT = 8
);
    import mpmc10_pkg::*;

    localparam int PORTW = $clog2(NPORT);

    faxi_readwrite_request256_t req_i [NPORT];
    logic [NPORT-1:0]           req_valid_i;
    logic [NPORT-1:0]           lock_i;
    logic [NPORT-1:0]           req_ready_o;
    faxi_readwrite_request256_t req_o;
    logic                       req_valid_o;
    logic                       req_ready_i;
    logic [PORTW-1:0]           req_port_o;
    logic                       locked_o;

    modport slave (
        input  req_i, req_valid_i, lock_i, req_ready_i,
        output req_ready_o, req_o, req_valid_o, req_port_o, locked_o
    );

    modport master (
        output req_i, req_valid_i, lock_i, req_ready_i,
        input  req_ready_o, req_o, req_valid_o, req_port_o, locked_o
    );

endinterface

// File: rtl/mpmc10_req_arb256_skid.sv
// Two-entry main/skid output register for a 256-bit request beat plus a
// port tag. in_ready depends only on registered state, so there is no
// combinational path from out_ready back to in_ready.
//   clk, rstn            : clock, async active-low reset
//   in_data/in_port      : beat and tag offered upstream
//   in_valid/in_ready    : upstream handshake
//   out_data/out_port    : registered beat and tag
//   out_valid/out_ready  : downstream handshake
module mpmc10_skid256
    import mpmc10_pkg::*;
#(
    parameter int PORTW = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  faxi_readwrite_request256_t in_data,
    input  logic [PORTW-1:0]           in_port,
    input  logic                       in_valid,
    output logic                       in_ready,
    output faxi_readwrite_request256_t out_data,
    output logic [PORTW-1:0]           out_port,
    output logic                       out_valid,
    input  logic                       out_ready
);

    faxi_readwrite_request256_t skid_data;
    logic [PORTW-1:0]           skid_port;
    logic                       skid_valid;
    logic                       push;
    logic                       main_free;

    // Ready is held low while reset is asserted so no beat is offered.
    assign in_ready  = rstn & ~skid_valid;
    assign push      = in_valid & in_ready;
    assign main_free = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data   <= '0;
            out_port   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_port  <= '0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // A full skid implies in_ready was low, so it never competes with push.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_port   <= skid_port;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (push) begin
                out_data  <= in_data;
                out_port  <= in_port;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            skid_data  <= in_data;
            skid_port  <= in_port;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/mpmc10_req_arb256.sv
// Round-robin arbiter sharing one 256-bit request path among NPORT
// requesters, with locked multi-beat bursts and a forced release after
// MAX_LOCK cycles. The winning beat goes through a main/skid register.
//   clk, rstn : clock, async active-low reset
//   bus       : request bundle (slave side), see mpmc10_req_arb256_if
module mpmc10_req_arb256
    import mpmc10_pkg::*;
#(
    parameter int NPORT    = 8,
    parameter int PORTW    = $clog2(NPORT),
    parameter int MAX_LOCK = MPMC10_MAX_LOCK_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    mpmc10_req_arb256_if.slave bus
);

    localparam int CNTW = $clog2(MAX_LOCK);

    arb_state_t                 state, state_n;
    logic [PORTW-1:0]           rr_ptr, rr_ptr_n;
    logic [PORTW-1:0]           lock_port, lock_port_n;
    logic [CNTW-1:0]            lock_cnt, lock_cnt_n;
    logic [PORTW-1:0]           grant;
    logic                       grant_hit;
    logic                       can_accept;
    logic                       xfer;
    faxi_readwrite_request256_t grant_req;

    always_comb begin : grant_sel
        int unsigned idx;
        grant     = lock_port;
        grant_hit = 1'b0;
        idx       = 0;
        if (state == LOCKED) begin
            grant_hit = bus.req_valid_i[lock_port];
        end else begin
            // Walk offsets from farthest to nearest so the first valid port
            // after rr_ptr is the last one written and therefore wins.
            for (int unsigned k = NPORT; k >= 1; k--) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= NPORT) idx = idx - NPORT;
                if (bus.req_valid_i[PORTW'(idx)]) begin
                    grant     = PORTW'(idx);
                    grant_hit = 1'b1;
                end
            end
        end
    end

    assign xfer      = grant_hit & can_accept;
    assign grant_req = bus.req_i[grant];

    always_comb begin
        bus.req_ready_o        = '0;
        bus.req_ready_o[grant] = xfer;
    end

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        lock_port_n = lock_port;
        lock_cnt_n  = lock_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (bus.lock_i[grant]) begin
                        state_n     = LOCKED;
                        lock_port_n = grant;
                        lock_cnt_n  = '0;
                    end else begin
                        rr_ptr_n = grant;
                    end
                end
            end
            LOCKED: begin
                lock_cnt_n = lock_cnt + CNTW'(1);
                if ((xfer && !bus.lock_i[lock_port]) || lock_cnt == CNTW'(MAX_LOCK - 1)) begin
                    state_n    = IDLE;
                    rr_ptr_n   = lock_port;
                    lock_cnt_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_ptr    <= PORTW'(NPORT - 1);
            lock_port <= '0;
            lock_cnt  <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            lock_port <= lock_port_n;
            lock_cnt  <= lock_cnt_n;
        end
    end

    assign bus.locked_o = (state == LOCKED);

    mpmc10_skid256 #(
        .PORTW(PORTW)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (grant_req),
        .in_port  (grant),
        .in_valid (grant_hit),
        .in_ready (can_accept),
        .out_data (bus.req_o),
        .out_port (bus.req_port_o),
        .out_valid(bus.req_valid_o),
        .out_ready(bus.req_ready_i)
    );

endmodule

// File: tb/tb_mpmc10_req_arb256.sv
// Bench for mpmc10_req_arb256: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_mpmc10_req_arb256;
    import mpmc10_pkg::*;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int ML = 8;

    typedef struct packed {
        faxi_readwrite_request256_t r;
        logic [PW-1:0]              port;
    } beat_t;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mpmc10_req_arb256_if #(.NPORT(N)) bus ();

    mpmc10_req_arb256 #(
        .NPORT   (N),
        .PORTW   (PW),
        .MAX_LOCK(ML)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int last_g;

    // Reference model: output path is a FIFO of at most two beats,
    // priority is "the port after the last one served".
    beat_t q[$];
    int    m_rr;
    bit    m_locked;
    int    m_owner;
    int    m_held;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic faxi_readwrite_request256_t rand_req(input int p);
        faxi_readwrite_request256_t r;
        r.tid = 4'(p);
        r.we  = 1'($urandom);
        r.adr = $urandom;
        r.sel = $urandom;
        for (int w = 0; w < 8; w++) r.dat[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rr     = N - 1;
        m_locked = 1'b0;
        m_owner  = 0;
        m_held   = 0;
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        int g = -1;
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int off = 1; off <= N; off++)
            if (g < 0 && v[(m_rr + off) % N]) g = (m_rr + off) % N;
        return g;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] lk, input logic rdy);
        int         g;
        logic [N-1:0] er;
        bit         fire;
        beat_t      b;
        @(negedge clk);
        bus.req_valid_i = v;
        bus.lock_i      = lk;
        bus.req_ready_i = rdy;
        for (int p = 0; p < N; p++) bus.req_i[p] = rand_req(p);
        #1;
        g    = model_pick(v);
        fire = (g >= 0) && (q.size() < 2);
        er   = fire ? (N'(1) << g) : '0;
        chk("ready_o", bus.req_ready_o, er);
        chk("valid_o", bus.req_valid_o, q.size() > 0);
        chk("locked_o", bus.locked_o, m_locked);
        if (q.size() > 0) begin
            chk("req_o", bus.req_o, q[0].r);
            chk("port_o", bus.req_port_o, q[0].port);
        end
        last_g = -1;
        for (int p = 0; p < N; p++) if (bus.req_ready_o[p]) last_g = p;
        // advance the model across the coming posedge
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (fire) begin
            b.r    = bus.req_i[g];
            b.port = PW'(g);
            q.push_back(b);
        end
        if (!m_locked) begin
            if (fire) begin
                if (lk[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_held   = 0;
                end else begin
                    m_rr = g;
                end
            end
        end else if ((fire && !lk[m_owner]) || m_held == ML - 1) begin
            m_locked = 1'b0;
            m_rr     = m_owner;
        end else begin
            m_held++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int seq_a [3] = '{0, 3, 5};
        rstn            = 1'b0;
        bus.req_valid_i = '0;
        bus.lock_i      = '0;
        bus.req_ready_i = 1'b0;
        for (int p = 0; p < N; p++) bus.req_i[p] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid_o", bus.req_valid_o, 1'b0);
        chk("rst_ready_o", bus.req_ready_o, '0);
        chk("rst_locked_o", bus.locked_o, 1'b0);
        chk("rst_port_o", bus.req_port_o, '0);
        chk("rst_req_o", bus.req_o, '0);
        rstn = 1'b1;

        // ports 0,3,5 continuously valid
        for (int i = 0; i < 9; i++) begin
            cycle(8'b0010_1001, '0, 1'b1);
            chk("rr_035", last_g, seq_a[i % 3]);
        end

        // locked burst from port 2 while ports 1 and 6 wait
        cycle(8'b0000_0010, '0, 1'b1);
        chk("lock_pre", last_g, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(8'b0100_0110, (i < 3) ? 8'b0000_0100 : 8'b0, 1'b1);
            chk("lock_burst", last_g, 2);
        end
        cycle(8'b0100_0010, '0, 1'b1);
        chk("after_lock_6", last_g, 6);
        cycle(8'b0100_0010, '0, 1'b1);
        chk("after_lock_1", last_g, 1);

        // forced release: port 4 locks then drops valid, port 5 waits
        cycle(8'b0001_0000, 8'b0001_0000, 1'b1);
        chk("force_lock", last_g, 4);
        for (int i = 0; i < ML; i++) begin
            cycle(8'b0010_0000, '0, 1'b1);
            chk("force_hold_grant", last_g, -1);
            chk("force_hold_locked", bus.locked_o, 1'b1);
        end
        cycle(8'b0010_0000, '0, 1'b1);
        chk("force_rel_locked", bus.locked_o, 1'b0);
        chk("force_rel_grant", last_g, 5);

        // port 7 streaming with a 3-cycle downstream stall
        repeat (3) cycle(8'h80, '0, 1'b1);
        cycle(8'h80, '0, 1'b0);
        chk("stall_skid_load", last_g, 7);
        repeat (2) begin
            cycle(8'h80, '0, 1'b0);
            chk("skid_block", bus.req_ready_o, '0);
        end
        repeat (5) cycle(8'h80, '0, 1'b1);
        repeat (3) cycle('0, '0, 1'b1);

        // reset in LOCKED with the skid full
        cycle(8'h40, 8'h40, 1'b0);
        cycle(8'h40, 8'h40, 1'b0);
        cycle(8'h40, 8'h40, 1'b0);
        chk("pre_rst_ready", bus.req_ready_o, '0);
        chk("pre_rst_locked", bus.locked_o, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid_o", bus.req_valid_o, 1'b0);
        chk("mid_rst_ready_o", bus.req_ready_o, '0);
        chk("mid_rst_locked_o", bus.locked_o, 1'b0);
        bus.req_valid_i = '0;
        bus.lock_i      = '0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // wrap from rr_ptr = N-1 with ports 0 and N-1 valid
        for (int i = 0; i < 6; i++) begin
            cycle(8'h81, '0, 1'b1);
            chk("wrap_seq", last_g, (i % 2 == 0) ? 0 : N - 1);
        end

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle(N'($urandom), N'($urandom & $urandom), $urandom_range(0, 3) != 0);
        repeat (4) cycle('0, '0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mpmc10_req_arb256.md
Name: mpmc10_req_arb256

Overview:
- Round-robin arbiter that shares one 256-bit read/write request path among NPORT requesters in the mpmc10 multiport memory controller.
- Selects one port per beat and supports locked multi-beat bursts with a forced-release timeout.
- Delivers the winning request through a registered output stage with a skid buffer, so there is no combinational path from req_ready_i to req_ready_o.
- Sits between the per-port request FIFOs and the 256-bit request register stage that feeds the controller state machine.

Parameters:
- NPORT, 8, number of requesters; legal range 2..16.
- PORTW, $clog2(NPORT), width of the port-index fields.
- MAX_LOCK, 64, maximum cycles a locked port may hold the grant before release is forced; legal range ≥ 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset; asynchronous assert, active-low.
- req_i  in  NPORT x faxi_readwrite_request256_t  per-port request beat.
- req_valid_i  in  NPORT  per-port request valid.
- lock_i  in  NPORT  per-port burst lock; sampled with the accepted beat.
- req_ready_o  out  NPORT  per-port accept; at most one bit set.
- req_o  out  faxi_readwrite_request256_t  arbitrated request beat.
- req_valid_o  out  1  req_o valid.
- req_ready_i  in  1  downstream accept.
- req_port_o  out  PORTW  source port of req_o.
- locked_o  out  1  arbiter is in LOCKED state.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values:
  - All outputs 0; skid buffer empty; state IDLE; lock counter 0.
  - rr_ptr = NPORT-1, so port 0 has first priority.
  - Beats in flight when rstn asserts are discarded. No partial state survives.
- Selection (IDLE):
  - Grant g is the first port with req_valid_i set, searching rr_ptr+1, rr_ptr+2, ... modulo NPORT.
  - The search is combinational from registered rr_ptr.
- Selection (LOCKED): g = lock_port; all other ports are masked.
- Accept rule:
  - can_accept = ~skid_valid. It is a registered term only.
  - req_ready_o[g] = can_accept & req_valid_i[g]. All other bits are 0.
  - A beat transfers when req_ready_o[g] is 1.
- Output stage:
  - On accept with the main register empty, or with the main register draining (req_valid_o & req_ready_i), the beat loads into the main register.
  - On accept with the main register stalled, the beat loads into the skid register.
  - When the main register drains and the skid is full, the skid beat moves to the main register and the skid empties.
  - Latency from accept to req_valid_o is 1 cycle when the output is free.
  - req_o and req_port_o hold stable while req_valid_o=1 and req_ready_i=0.
  - Beat order is preserved and no beat is dropped or duplicated.
- FSM IDLE -> LOCKED: an accepted beat has lock_i[g]=1. Then lock_port = g and lock_cnt = 0.
- FSM LOCKED behaviour:
  - lock_cnt increments every cycle, including cycles where lock_port drops valid.
  - The grant waits on lock_port; it is not reassigned.
- FSM LOCKED -> IDLE: an accepted beat with lock_i[lock_port]=0, or lock_cnt reaching MAX_LOCK-1 (forced release). On a forced release, a beat accepted in that same cycle still completes.
- rr_ptr update:
  - rr_ptr = g on every accepted beat in IDLE that does not enter LOCKED.
  - rr_ptr = lock_port on exit from LOCKED.
  - A port is therefore lowest priority immediately after its turn.
- Simultaneous events:
  - Accept and drain in the same cycle with skid empty: the main register reloads; no bubble.
  - All valids low: no grant; rr_ptr unchanged.
- Boundaries:
  - rr_ptr = NPORT-1 wraps the search to port 0.
  - Skid full forces all req_ready_o to 0 for at least one cycle.
  - Sustained throughput is 1 beat/clk when req_ready_i is held high.

Decomposition:
- mpmc10_pkg already holds faxi_readwrite_request256_t.
- Add to mpmc10_pkg:
  - typedef arb_state_t {IDLE, LOCKED}.
  - Constant MPMC10_MAX_LOCK_DEF = 64.
- Sub-module mpmc10_skid256: a 2-entry main/skid register for faxi_readwrite_request256_t plus a PORTW tag, with a valid/ready interface. It is reusable for other 256-bit request paths.

Test Plan:
- Reset, then ports 0,3,5 valid continuously with req_ready_i=1:
  - Grants are 0,3,5,0,3,5...
  - req_valid_o rises 1 cycle after the first accept.
  - req_port_o tracks the grant sequence.
- Port 2 sends 4 beats with lock_i=1,1,1,0 while ports 1 and 6 are valid:
  - Four consecutive beats come from port 2.
  - The next grant is port 6, then port 1.
- With MAX_LOCK=8, port 4 locks then drops valid:
  - The grant stays on port 4 for 8 cycles.
  - Then locked_o falls and port 5 (valid) is granted.
- Port 7 streaming, req_ready_i low for 3 cycles:
  - One beat enters the skid, then all req_ready_o are 0.
  - On release, beats exit in order and none are lost; checked by a payload counter.
- rstn pulsed low mid-burst in LOCKED with the skid full:
  - req_valid_o=0, req_ready_o=0 and locked_o=0 immediately.
  - The first grant after release is port 0.
- rr_ptr=NPORT-1 with only port NPORT-1 and port 0 valid: the search wraps correctly and grants alternate 0, NPORT-1.
